// File: rtl/cprv_pkg.sv
// Shared RV64I decode constants for the cprv64g pipeline stages.
// Holds opcode values, the funct3 ALU-op encoding and the two legal funct7 patterns.
package cprv_pkg;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      F3_ADD_SUB = 3'b000,
      F3_SLL     = 3'b001,
      F3_SLT     = 3'b010,
      F3_SLTU    = 3'b011,
      F3_XOR     = 3'b100,
      F3_SRL_SRA = 3'b101,
      F3_OR      = 3'b110,
      F3_AND     = 3'b111
   } alu_op_e;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/cprv_alu.sv
// Combinational RV64I integer ALU: OP, OP_IMM, OP_32, OP_IMM_32 and load/store address generation.
// Flags any unsupported opcode/funct combination as illegal and then returns zero.
module cprv_alu
   import cprv_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] rs1,
   input  logic [DATA_WIDTH-1:0] rs2,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  illegal
);

   logic [DATA_WIDTH-1:0] op2;
   logic [5:0]            shamt;
   logic [31:0]           w_res;
   logic                  is_imm;
   logic                  base_ok;

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      w_res   = '0;
      is_imm  = (opcode == OPC_OP_IMM) || (opcode == OPC_OP_IMM_32);
      op2     = ((opcode == OPC_OP) || (opcode == OPC_OP_32)) ? rs2 : imm;
      shamt   = op2[5:0];
      // immediate forms carry no funct7 except for shifts
      base_ok = is_imm || (funct7 == F7_BASE);

      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            case (alu_op_e'(funct3))
               F3_ADD_SUB: begin
                  if (base_ok)                             result = rs1 + op2;
                  else if (!is_imm && (funct7 == F7_ALT))  result = rs1 - op2;
                  else                                     illegal = 1'b1;
               end
               F3_SLL: begin
                  // OP_IMM uses funct7[0] as shamt[5]
                  if (is_imm ? (funct7[6:1] == F7_BASE[6:1]) : (funct7 == F7_BASE))
                     result = rs1 << shamt;
                  else
                     illegal = 1'b1;
               end
               F3_SRL_SRA: begin
                  if (is_imm ? (funct7[6:1] == F7_BASE[6:1]) : (funct7 == F7_BASE))
                     result = rs1 >> shamt;
                  else if (is_imm ? (funct7[6:1] == F7_ALT[6:1]) : (funct7 == F7_ALT))
                     result = $signed(rs1) >>> shamt;
                  else
                     illegal = 1'b1;
               end
               F3_SLT: begin
                  result  = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1) < $signed(op2))};
                  illegal = !base_ok;
               end
               F3_SLTU: begin
                  result  = {{(DATA_WIDTH-1){1'b0}}, (rs1 < op2)};
                  illegal = !base_ok;
               end
               F3_XOR: begin
                  result  = rs1 ^ op2;
                  illegal = !base_ok;
               end
               F3_OR: begin
                  result  = rs1 | op2;
                  illegal = !base_ok;
               end
               F3_AND: begin
                  result  = rs1 & op2;
                  illegal = !base_ok;
               end
            endcase
         end

         OPC_OP_32, OPC_OP_IMM_32: begin
            case (alu_op_e'(funct3))
               F3_ADD_SUB: begin
                  if (base_ok)                             w_res = rs1[31:0] + op2[31:0];
                  else if (!is_imm && (funct7 == F7_ALT))  w_res = rs1[31:0] - op2[31:0];
                  else                                     illegal = 1'b1;
               end
               F3_SLL: begin
                  if (funct7 == F7_BASE) w_res = rs1[31:0] << shamt[4:0];
                  else                   illegal = 1'b1;
               end
               F3_SRL_SRA: begin
                  if (funct7 == F7_BASE)     w_res = rs1[31:0] >> shamt[4:0];
                  else if (funct7 == F7_ALT) w_res = $signed(rs1[31:0]) >>> shamt[4:0];
                  else                       illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
            result = sext32(w_res);
         end

         OPC_LOAD, OPC_STORE: result = rs1 + op2;

         default: illegal = 1'b1;
      endcase

      if (illegal) result = '0;
   end

endmodule

// File: rtl/cprv_ex_stage.sv
// cprv64g execute stage: ALU evaluation behind a single registered EX->MEM slice.
// The slice advances whenever it is empty or MEM is taking its current contents.
module cprv_ex_stage
   import cprv_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_ex_i,
   output logic                   ready_ex_o,
   input  logic [DATA_WIDTH-1:0]  rs1_data_ex_i,
   input  logic [DATA_WIDTH-1:0]  rs2_data_ex_i,
   input  logic [4:0]             rd_addr_ex_i,
   input  logic                   rd_en_ex_i,
   input  logic [DATA_WIDTH-1:0]  imm_data_ex_i,
   input  logic [6:0]             opcode_ex_i,
   input  logic [2:0]             funct3_ex_i,
   input  logic [INSTR_WIDTH-26:0] funct7_ex_i,
   input  logic                   mem_w_en_ex_i,
   output logic                   valid_mem_o,
   input  logic                   ready_mem_i,
   output logic [DATA_WIDTH-1:0]  alu_result_mem_o,
   output logic [DATA_WIDTH-1:0]  store_data_mem_o,
   output logic [4:0]             rd_addr_mem_o,
   output logic                   rd_en_mem_o,
   output logic                   mem_r_en_mem_o,
   output logic                   mem_w_en_mem_o,
   output logic [2:0]             funct3_mem_o,
   output logic                   illegal_mem_o
);

   logic                  cke;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_illegal;

   assign cke        = ~valid_mem_o | ready_mem_i;
   assign ready_ex_o = cke;

   cprv_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .rs1     (rs1_data_ex_i),
      .rs2     (rs2_data_ex_i),
      .imm     (imm_data_ex_i),
      .opcode  (opcode_ex_i),
      .funct3  (funct3_ex_i),
      .funct7  (funct7_ex_i),
      .result  (alu_result),
      .illegal (alu_illegal)
   );

   // payload loads on every enabled cycle, even when valid_ex_i is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_mem_o      <= 1'b0;
         alu_result_mem_o <= '0;
         store_data_mem_o <= '0;
         rd_addr_mem_o    <= '0;
         rd_en_mem_o      <= 1'b0;
         mem_r_en_mem_o   <= 1'b0;
         mem_w_en_mem_o   <= 1'b0;
         funct3_mem_o     <= '0;
         illegal_mem_o    <= 1'b0;
      end else if (cke) begin
         valid_mem_o      <= valid_ex_i;
         alu_result_mem_o <= alu_result;
         store_data_mem_o <= rs2_data_ex_i;
         rd_addr_mem_o    <= rd_addr_ex_i;
         rd_en_mem_o      <= rd_en_ex_i & ~alu_illegal & (rd_addr_ex_i != 5'd0);
         mem_r_en_mem_o   <= (opcode_ex_i == OPC_LOAD) & ~alu_illegal;
         mem_w_en_mem_o   <= mem_w_en_ex_i & (opcode_ex_i == OPC_STORE) & ~alu_illegal;
         funct3_mem_o     <= funct3_ex_i;
         illegal_mem_o    <= alu_illegal;
      end
   end

endmodule

// File: tb/tb_cprv_ex_stage.sv
// Self-checking bench for cprv_ex_stage: directed cases plus randomized traffic
// compared every cycle against an instruction-level reference model.
module tb_cprv_ex_stage;

   localparam logic [6:0] C_OP = 7'h33, C_OPI = 7'h13, C_OP32 = 7'h3B, C_OPI32 = 7'h1B;
   localparam logic [6:0] C_LD = 7'h03, C_ST = 7'h23;

   typedef enum int {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
                     M_ADDW, M_SUBW, M_SLLW, M_SRLW, M_SRAW, M_AGEN, M_ILL} mn_e;

   typedef struct packed {
      logic        valid;
      logic [63:0] result;
      logic [63:0] store;
      logic [4:0]  rd;
      logic        rd_en;
      logic        r_en;
      logic        w_en;
      logic [2:0]  f3;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_ex_i, ready_ex_o;
   logic [63:0] rs1_data_ex_i, rs2_data_ex_i, imm_data_ex_i;
   logic [4:0]  rd_addr_ex_i;
   logic        rd_en_ex_i;
   logic [6:0]  opcode_ex_i;
   logic [2:0]  funct3_ex_i;
   logic [6:0]  funct7_ex_i;
   logic        mem_w_en_ex_i;
   logic        valid_mem_o, ready_mem_i;
   logic [63:0] alu_result_mem_o, store_data_mem_o;
   logic [4:0]  rd_addr_mem_o;
   logic        rd_en_mem_o, mem_r_en_mem_o, mem_w_en_mem_o;
   logic [2:0]  funct3_mem_o;
   logic        illegal_mem_o;

   int checks = 0;
   int errors = 0;
   int n_acc  = 0;
   int n_cons = 0;
   logic started = 1'b0;
   exp_t exp_q;

   always #5 clk = ~clk;

   cprv_ex_stage #(.DATA_WIDTH(64), .INSTR_WIDTH(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .valid_ex_i       (valid_ex_i),
      .ready_ex_o       (ready_ex_o),
      .rs1_data_ex_i    (rs1_data_ex_i),
      .rs2_data_ex_i    (rs2_data_ex_i),
      .rd_addr_ex_i     (rd_addr_ex_i),
      .rd_en_ex_i       (rd_en_ex_i),
      .imm_data_ex_i    (imm_data_ex_i),
      .opcode_ex_i      (opcode_ex_i),
      .funct3_ex_i      (funct3_ex_i),
      .funct7_ex_i      (funct7_ex_i),
      .mem_w_en_ex_i    (mem_w_en_ex_i),
      .valid_mem_o      (valid_mem_o),
      .ready_mem_i      (ready_mem_i),
      .alu_result_mem_o (alu_result_mem_o),
      .store_data_mem_o (store_data_mem_o),
      .rd_addr_mem_o    (rd_addr_mem_o),
      .rd_en_mem_o      (rd_en_mem_o),
      .mem_r_en_mem_o   (mem_r_en_mem_o),
      .mem_w_en_mem_o   (mem_w_en_mem_o),
      .funct3_mem_o     (funct3_mem_o),
      .illegal_mem_o    (illegal_mem_o)
   );

   // ---------------- reference model: mnemonic table, then arithmetic ----------------
   function automatic mn_e decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
      mn_e m;
      m = M_ILL;
      if (opc == C_OP) begin
         case ({f7, f3})
            {7'h00, 3'd0}: m = M_ADD;   {7'h20, 3'd0}: m = M_SUB;
            {7'h00, 3'd1}: m = M_SLL;   {7'h00, 3'd2}: m = M_SLT;
            {7'h00, 3'd3}: m = M_SLTU;  {7'h00, 3'd4}: m = M_XOR;
            {7'h00, 3'd5}: m = M_SRL;   {7'h20, 3'd5}: m = M_SRA;
            {7'h00, 3'd6}: m = M_OR;    {7'h00, 3'd7}: m = M_AND;
            default:       m = M_ILL;
         endcase
      end else if (opc == C_OPI) begin
         case (f3)
            3'd0: m = M_ADD;  3'd2: m = M_SLT; 3'd3: m = M_SLTU;
            3'd4: m = M_XOR;  3'd6: m = M_OR;  3'd7: m = M_AND;
            3'd1: m = (f7 / 2 == 0) ? M_SLL : M_ILL;
            default: m = (f7 / 2 == 0) ? M_SRL : ((f7 / 2 == 7'h10) ? M_SRA : M_ILL);
         endcase
      end else if (opc == C_OP32) begin
         case ({f7, f3})
            {7'h00, 3'd0}: m = M_ADDW;  {7'h20, 3'd0}: m = M_SUBW;
            {7'h00, 3'd1}: m = M_SLLW;  {7'h00, 3'd5}: m = M_SRLW;
            {7'h20, 3'd5}: m = M_SRAW;  default:       m = M_ILL;
         endcase
      end else if (opc == C_OPI32) begin
         if (f3 == 3'd0)                      m = M_ADDW;
         else if (f3 == 3'd1 && f7 == 7'h00)  m = M_SLLW;
         else if (f3 == 3'd5 && f7 == 7'h00)  m = M_SRLW;
         else if (f3 == 3'd5 && f7 == 7'h20)  m = M_SRAW;
      end else if (opc == C_LD || opc == C_ST) begin
         m = M_AGEN;
      end
      return m;
   endfunction

   function automatic logic [63:0] w_sext(input logic [31:0] v);
      logic signed [31:0] s;
      logic signed [63:0] w;
      s = v;
      w = s;
      return w;
   endfunction

   function automatic logic [63:0] compute(input mn_e m, input logic [63:0] a, input logic [63:0] b);
      int sh6, sh5;
      logic signed [63:0] sa;
      sh6 = int'(b % 64);
      sh5 = int'(b % 32);
      case (m)
         M_ADD, M_AGEN: return a + b;
         M_SUB:  return a - b;
         M_SLL:  return a << sh6;
         M_SRL:  return a >> sh6;
         M_SRA:  begin sa = a; return sa >>> sh6; end
         M_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         M_SLTU: return (a < b) ? 64'd1 : 64'd0;
         M_XOR:  return a ^ b;
         M_OR:   return a | b;
         M_AND:  return a & b;
         M_ADDW: return w_sext(32'((a + b) % 64'h1_0000_0000));
         M_SUBW: return w_sext(32'((a - b) % 64'h1_0000_0000));
         M_SLLW: return w_sext(32'((a << sh5) % 64'h1_0000_0000));
         M_SRLW: return w_sext(32'((a % 64'h1_0000_0000) >> sh5));
         M_SRAW: begin sa = w_sext(a[31:0]); return w_sext(32'(sa >>> sh5)); end
         default: return 64'd0;
      endcase
   endfunction

   function automatic exp_t model_ex(input logic v, input logic [63:0] a, input logic [63:0] r2,
                                     input logic [63:0] im, input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] rd, input logic rde,
                                     input logic we);
      exp_t e;
      mn_e  m;
      m         = decode(opc, f3, f7);
      e.valid   = v;
      e.illegal = (m == M_ILL);
      e.result  = e.illegal ? 64'd0 : compute(m, a, (opc == C_OP || opc == C_OP32) ? r2 : im);
      e.store   = r2;
      e.rd      = rd;
      e.f3      = f3;
      e.rd_en   = rde && !e.illegal && (rd != 5'd0);
      e.r_en    = (opc == C_LD);
      e.w_en    = we && (opc == C_ST);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- cycle model and per-cycle compare ----------------
   always @(posedge clk) begin
      started <= 1'b1;
      if (!rst_n)
         exp_q <= '0;
      else if (!exp_q.valid || ready_mem_i)
         exp_q <= model_ex(valid_ex_i, rs1_data_ex_i, rs2_data_ex_i, imm_data_ex_i, opcode_ex_i,
                           funct3_ex_i, funct7_ex_i, rd_addr_ex_i, rd_en_ex_i, mem_w_en_ex_i);
   end

   always @(negedge clk) begin
      if (started) begin
         check("ready_ex", 64'(ready_ex_o), 64'(!exp_q.valid || ready_mem_i));
         check("valid_mem", 64'(valid_mem_o), 64'(exp_q.valid));
         if (exp_q.valid) begin
            check("alu_result", alu_result_mem_o, exp_q.result);
            check("store_data", store_data_mem_o, exp_q.store);
            check("rd_addr", 64'(rd_addr_mem_o), 64'(exp_q.rd));
            check("rd_en", 64'(rd_en_mem_o), 64'(exp_q.rd_en));
            check("mem_r_en", 64'(mem_r_en_mem_o), 64'(exp_q.r_en));
            check("mem_w_en", 64'(mem_w_en_mem_o), 64'(exp_q.w_en));
            check("funct3", 64'(funct3_mem_o), 64'(exp_q.f3));
            check("illegal", 64'(illegal_mem_o), 64'(exp_q.illegal));
         end
         if (rst_n && valid_ex_i && ready_ex_o) n_acc++;
         if (rst_n && valid_mem_o && ready_mem_i) n_cons++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                        input logic [4:0] rd, input logic rde, input logic we);
      valid_ex_i    = 1'b1;
      opcode_ex_i   = opc;
      funct3_ex_i   = f3;
      funct7_ex_i   = f7;
      rs1_data_ex_i = a;
      rs2_data_ex_i = b;
      imm_data_ex_i = im;
      rd_addr_ex_i  = rd;
      rd_en_ex_i    = rde;
      mem_w_en_ex_i = we;
      $display("drive opc=%h f3=%0d f7=%h rs1=%h rs2=%h imm=%h rd=%0d", opc, f3, f7, a, b, im, rd);
   endtask

   function automatic logic [63:0] pick64();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return '1;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'h0000_0000_7FFF_FFFF;
         4: return 64'h0000_0000_8000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      exp_t pin;
      // pin the model with hand-computed values
      pin = model_ex(1'b1, 64'h8000_0000_0000_0000, 64'd63, 64'd0, C_OP, 3'd5, 7'h20, 5'd1, 1'b1, 1'b0);
      check("model_sra", pin.result, 64'hFFFF_FFFF_FFFF_FFFF);
      pin = model_ex(1'b1, 64'd1, '1, 64'd0, C_OP, 3'd3, 7'h00, 5'd1, 1'b1, 1'b0);
      check("model_sltu", pin.result, 64'd1);
      pin = model_ex(1'b1, 64'd1, '1, 64'd0, C_OP, 3'd2, 7'h00, 5'd1, 1'b1, 1'b0);
      check("model_slt", pin.result, 64'd0);
      pin = model_ex(1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd0, C_OP32, 3'd5, 7'h00, 5'd1, 1'b1, 1'b0);
      check("model_srlw", pin.result, 64'd1);
      pin = model_ex(1'b1, 64'd1, 64'd0, 64'd32, C_OPI, 3'd1, 7'h00, 5'd1, 1'b1, 1'b0);
      check("model_slli32", pin.result, 64'h0000_0001_0000_0000);
      pin = model_ex(1'b1, 64'd1, 64'd0, 64'd3, C_OPI32, 3'd1, 7'h20, 5'd1, 1'b1, 1'b0);
      check("model_slliw_bad", 64'(pin.illegal), 64'd1);

      // reset held two cycles with valid asserted
      rst_n = 1'b0;
      ready_mem_i = 1'b1;
      drive(C_OP, 3'd0, 7'h00, 64'd9, 64'd9, 64'd9, 5'd7, 1'b1, 1'b1);
      step();
      step();
      check("rst_valid", 64'(valid_mem_o), 64'd0);
      check("rst_result", alu_result_mem_o, 64'd0);
      check("rst_misc", {store_data_mem_o[31:0], 19'd0, rd_addr_mem_o, rd_en_mem_o, mem_r_en_mem_o,
                         mem_w_en_mem_o, funct3_mem_o, illegal_mem_o}, 64'd0);
      rst_n = 1'b1;
      valid_ex_i = 1'b0;
      check("ready_after_rst", 64'(ready_ex_o), 64'd1);
      step();
      check("ready_after_rst2", 64'(ready_ex_o), 64'd1);

      drive(C_OP, 3'd0, 7'h20, 64'd5, 64'd7, 64'd0, 5'd3, 1'b1, 1'b0);
      step();
      check("sub_result", alu_result_mem_o, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_rd_en", 64'(rd_en_mem_o), 64'd1);
      check("sub_valid", 64'(valid_mem_o), 64'd1);

      drive(C_OP32, 3'd0, 7'h00, 64'h7FFF_FFFF, 64'd1, 64'd0, 5'd4, 1'b1, 1'b0);
      step();
      check("addw", alu_result_mem_o, 64'hFFFF_FFFF_8000_0000);

      drive(C_OPI32, 3'd5, 7'h20, 64'h8000_0000, 64'd0, 64'd4, 5'd5, 1'b1, 1'b0);
      step();
      check("sraiw", alu_result_mem_o, 64'hFFFF_FFFF_F800_0000);

      drive(C_ST, 3'd3, 7'h11, 64'h1000, 64'hAB, -64'sd8, 5'd6, 1'b0, 1'b1);
      step();
      check("st_addr", alu_result_mem_o, 64'hFF8);
      check("st_data", store_data_mem_o, 64'hAB);
      check("st_w_en", 64'(mem_w_en_mem_o), 64'd1);
      check("st_rd_en", 64'(rd_en_mem_o), 64'd0);

      drive(7'h7F, 3'd0, 7'h00, 64'd1, 64'd2, 64'd3, 5'd4, 1'b1, 1'b1);
      step();
      check("ill_flag", 64'(illegal_mem_o), 64'd1);
      check("ill_enables", {61'd0, rd_en_mem_o, mem_r_en_mem_o, mem_w_en_mem_o}, 64'd0);
      check("ill_result", alu_result_mem_o, 64'd0);

      drive(C_OPI, 3'd0, 7'h00, 64'd10, 64'd0, 64'd5, 5'd0, 1'b1, 1'b0);
      step();
      check("addi_x0_rd_en", 64'(rd_en_mem_o), 64'd0);
      check("addi_x0_ill", 64'(illegal_mem_o), 64'd0);
      check("addi_x0_res", alu_result_mem_o, 64'd15);

      // stall: A captured, B waits while MEM is not ready
      valid_ex_i = 1'b0;
      step();
      ready_mem_i = 1'b0;
      drive(C_OP, 3'd0, 7'h00, 64'd1, 64'd2, 64'd0, 5'd1, 1'b1, 1'b0);
      step();
      drive(C_OP, 3'd0, 7'h00, 64'd10, 64'd20, 64'd0, 5'd2, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("stall_ready", 64'(ready_ex_o), 64'd0);
         check("stall_hold", alu_result_mem_o, 64'd3);
         check("stall_rd", 64'(rd_addr_mem_o), 64'd1);
         step();
      end
      ready_mem_i = 1'b1;
      #1;
      check("unstall_ready", 64'(ready_ex_o), 64'd1);
      step();
      valid_ex_i = 1'b0;
      check("stall_next", alu_result_mem_o, 64'd30);
      check("stall_next_rd", 64'(rd_addr_mem_o), 64'd2);
      step();
      check("stall_drained", 64'(valid_mem_o), 64'd0);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         valid_ex_i    = ($urandom_range(0, 9) < 8);
         ready_mem_i   = ($urandom_range(0, 9) < 7);
         rs1_data_ex_i = pick64();
         rs2_data_ex_i = pick64();
         imm_data_ex_i = ($urandom_range(0, 1) == 1) ? pick64() : 64'($urandom_range(0, 70));
         case ($urandom_range(0, 7))
            0, 7: opcode_ex_i = C_OP;
            1: opcode_ex_i = C_OPI;
            2: opcode_ex_i = C_OP32;
            3: opcode_ex_i = C_OPI32;
            4: opcode_ex_i = C_LD;
            5: opcode_ex_i = C_ST;
            default: opcode_ex_i = 7'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: funct7_ex_i = 7'h00;
            1: funct7_ex_i = 7'h20;
            2: funct7_ex_i = 7'h01;
            3: funct7_ex_i = 7'h21;
            default: funct7_ex_i = 7'($urandom);
         endcase
         funct3_ex_i   = 3'($urandom);
         rd_addr_ex_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         rd_en_ex_i    = 1'($urandom);
         mem_w_en_ex_i = 1'($urandom);
         step();
      end

      valid_ex_i  = 1'b0;
      ready_mem_i = 1'b1;
      step();
      step();
      check("transfer_count", 64'(n_cons), 64'(n_acc));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
